// File: rtl/user_pkg.sv
// ---------------------------------------------------------------------------
// user_pkg
// Shared types and constants for the edge-scan block.
//   scan_state_e : scan controller states (IDLE, FETCH, PROC, DONE)
//   scan_mode_e  : gradient direction selected by mode_i
//   ROM_ADDR_W / ROM_DATA_W : pixel-ROM bus widths
//   PIXEL_STRIDE : byte distance between consecutive pixels in the ROM
// ---------------------------------------------------------------------------
package user_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PROC  = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  typedef enum logic {
    MODE_HORIZ = 1'b0,
    MODE_VERT  = 1'b1
  } scan_mode_e;

  localparam int unsigned ROM_ADDR_W   = 32;
  localparam int unsigned ROM_DATA_W   = 32;
  localparam int unsigned PIXEL_STRIDE = 4;

endpackage

// File: rtl/user_edge_scan_if.sv
// ---------------------------------------------------------------------------
// user_edge_scan_if
// Pixel-ROM read bus between the scanner and the pixel memory.
//   rom_req_o   : read request, held until data is accepted
//   rom_addr_o  : byte address of the requested pixel
//   rom_data_i  : read data, pixel in the low bits
//   rom_valid_i : read data valid
// Modports:
//   master : the scanner (drives request/address)
//   slave  : the memory  (drives data/valid)
// ---------------------------------------------------------------------------
interface user_edge_scan_if;
  import user_pkg::*;

  logic                  rom_req_o;
  logic [ROM_ADDR_W-1:0] rom_addr_o;
  logic [ROM_DATA_W-1:0] rom_data_i;
  logic                  rom_valid_i;

  modport master (
    output rom_req_o,
    output rom_addr_o,
    input  rom_data_i,
    input  rom_valid_i
  );

  modport slave (
    input  rom_req_o,
    input  rom_addr_o,
    output rom_data_i,
    output rom_valid_i
  );

endinterface

// File: rtl/user_edge_linebuf.sv
// ---------------------------------------------------------------------------
// user_edge_linebuf
// One-row pixel store used as the vertical-gradient reference.
// Register based, one write port and one asynchronous read port. Reading and
// writing the same column in one cycle returns the old (previous-row) value,
// which is exactly what the vertical gradient needs.
// Contents are not reset: row 0 of every scan never uses them.
// Ports:
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write column
//   wdata_i : pixel to store
//   raddr_i : read column
//   rdata_o : stored pixel at raddr_i
// ---------------------------------------------------------------------------
module user_edge_linebuf #(
  parameter int unsigned ImgWidth   = 16,
  parameter int unsigned PixelWidth = 8
) (
  input  logic                        clk_i,
  input  logic                        we_i,
  input  logic [$clog2(ImgWidth)-1:0] waddr_i,
  input  logic [PixelWidth-1:0]       wdata_i,
  input  logic [$clog2(ImgWidth)-1:0] raddr_i,
  output logic [PixelWidth-1:0]       rdata_o
);

  logic [PixelWidth-1:0] mem [ImgWidth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/user_edge_scan.sv
// ---------------------------------------------------------------------------
// user_edge_scan
// Walks an ImgWidth x ImgHeight image stored in a pixel ROM, one pixel per
// read, and flags pixels whose gradient against a reference pixel exceeds a
// threshold. The reference is the left neighbour (horizontal mode) or the
// pixel above (vertical mode, taken from a one-row line buffer).
// Ports:
//   clk_i        : clock
//   rst_i        : synchronous active-high reset
//   start_i      : level input; a rising edge while idle starts a scan
//   mode_i       : 0 horizontal gradient, 1 vertical gradient
//   threshold_i  : edge threshold (strictly-greater compare)
//   rom          : pixel-ROM read bus (master side)
//   edge_valid_o : one-cycle strobe per processed pixel
//   edge_o       : edge flag, qualified by edge_valid_o
//   edge_count_o : saturating edge count of current/last scan
//   busy_o       : scan in progress
//   done_o       : one-cycle pulse when the last pixel has been processed
// ---------------------------------------------------------------------------
module user_edge_scan
  import user_pkg::*;
#(
  parameter int unsigned ImgWidth   = 16,
  parameter int unsigned ImgHeight  = 16,
  parameter int unsigned PixelWidth = 8,
  parameter logic [31:0] BaseAddr   = 32'h0,
  parameter int unsigned CntWidth   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [PixelWidth-1:0] threshold_i,
  user_edge_scan_if.master      rom,
  output logic                  edge_valid_o,
  output logic                  edge_o,
  output logic [CntWidth-1:0]   edge_count_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned ColW = $clog2(ImgWidth);
  localparam int unsigned RowW = $clog2(ImgHeight);
  localparam logic [ColW-1:0] LastCol = ColW'(ImgWidth - 1);
  localparam logic [RowW-1:0] LastRow = RowW'(ImgHeight - 1);

  // Unsigned |a - b| computed in one extra signed bit so the subtraction
  // cannot wrap.
  function automatic logic [PixelWidth-1:0] abs_diff(
    input logic [PixelWidth-1:0] a,
    input logic [PixelWidth-1:0] b
  );
    logic signed [PixelWidth:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? PixelWidth'(-d) : PixelWidth'(d);
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Control state (reset)
  scan_state_e         state_q, state_d;
  logic                start_q;
  logic [ColW-1:0]     col_q;
  logic [RowW-1:0]     row_q;
  logic [29:0]         idx_q;
  logic [CntWidth-1:0] edge_count_q;

  // Datapath state (no reset)
  scan_mode_e            mode_q;
  logic [PixelWidth-1:0] thr_q;
  logic [PixelWidth-1:0] pix_p0;
  logic [PixelWidth-1:0] hprev_q;

  logic                  start_rise;
  logic                  scan_go;
  logic                  accept;
  logic                  vld_p0;
  logic                  last_pix;
  logic [PixelWidth-1:0] lb_rdata;
  logic [PixelWidth-1:0] ref_pix;
  logic                  has_ref;
  logic                  edge_hit;

  assign start_rise = start_i & ~start_q;
  assign scan_go    = (state_q == ST_IDLE) && start_rise;
  assign accept     = (state_q == ST_FETCH) && rom.rom_valid_i;
  assign vld_p0     = (state_q == ST_PROC);
  assign last_pix   = (col_q == LastCol) && (row_q == LastRow);

  // ---- FSM ----------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_i;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_rise)      state_d = ST_FETCH;
      ST_FETCH: if (rom.rom_valid_i) state_d = ST_PROC;
      ST_PROC:  state_d = last_pix ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---- Position tracking and edge counter ---------------------------------
  // Column/row are kept as separate counters so the reference selection
  // needs no division; idx_q only feeds the ROM address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q        <= '0;
      row_q        <= '0;
      idx_q        <= '0;
      edge_count_q <= '0;
    end else if (scan_go) begin
      col_q        <= '0;
      row_q        <= '0;
      idx_q        <= '0;
      edge_count_q <= '0;
    end else if (vld_p0) begin
      idx_q <= idx_q + 1'b1;
      if (col_q == LastCol) begin
        col_q <= '0;
        row_q <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
      if (edge_hit) begin
        edge_count_q <= sat_inc(edge_count_q);
      end
    end
  end

  // ---- Stage p0: pixel capture from ROM -------------------------------------
  // Mode and threshold are latched at start so mid-scan input changes have
  // no effect; hprev_q holds the left neighbour for the horizontal gradient.
  always_ff @(posedge clk_i) begin
    if (scan_go) begin
      mode_q <= scan_mode_e'(mode_i);
      thr_q  <= threshold_i;
    end
    if (accept) begin
      pix_p0 <= rom.rom_data_i[PixelWidth-1:0];
    end
    if (vld_p0) begin
      hprev_q <= pix_p0;
    end
  end

  user_edge_linebuf #(
    .ImgWidth   (ImgWidth),
    .PixelWidth (PixelWidth)
  ) u_linebuf (
    .clk_i   (clk_i),
    .we_i    (vld_p0),
    .waddr_i (col_q),
    .wdata_i (pix_p0),
    .raddr_i (col_q),
    .rdata_o (lb_rdata)
  );

  // ---- Stage p0 evaluation: gradient against reference ------------------------
  // First column (horizontal) / first row (vertical) has no reference and
  // never flags, which also masks the unreset line buffer and hprev_q.
  always_comb begin
    ref_pix = hprev_q;
    has_ref = (col_q != '0);
    if (mode_q == MODE_VERT) begin
      ref_pix = lb_rdata;
      has_ref = (row_q != '0);
    end
  end

  assign edge_hit = vld_p0 && has_ref && (abs_diff(pix_p0, ref_pix) > thr_q);

  // Upper ROM data bits carry no pixel information.
  generate
    if (PixelWidth < ROM_DATA_W) begin : g_unused_data
      logic unused_rom_bits;
      assign unused_rom_bits = ^rom.rom_data_i[ROM_DATA_W-1:PixelWidth];
    end
  endgenerate

  // ---- Outputs ------------------------------------------------------------
  assign rom.rom_req_o  = (state_q == ST_FETCH);
  assign rom.rom_addr_o = BaseAddr + {idx_q, 2'b00};
  assign edge_valid_o   = vld_p0;
  assign edge_o         = edge_hit;
  assign edge_count_o   = edge_count_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_DONE);

endmodule

// File: tb/tb_user_edge_scan.sv
// ---------------------------------------------------------------------------
// tb_user_edge_scan
// Two scanners with identical image geometry share one stimulus stream: dut_a
// has a wide edge counter, dut_b a 2-bit counter to expose saturation. The
// bench plays the pixel ROM, and a reference model derives per-pixel edge
// flags and running counts from the image with plain index arithmetic.
// ---------------------------------------------------------------------------
module tb_user_edge_scan;
  import user_pkg::*;

  localparam int          W    = 4;
  localparam int          H    = 2;
  localparam int          N    = W * H;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          CWA  = 8;
  localparam int          CWB  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           mode = 1'b0;
  logic [7:0]     thr = 8'd0;
  logic           ev_a, e_a, busy_a, done_a;
  logic           ev_b, e_b, busy_b, done_b;
  logic [CWA-1:0] cnt_a;
  logic [CWB-1:0] cnt_b;

  user_edge_scan_if bus_a ();
  user_edge_scan_if bus_b ();

  user_edge_scan #(.ImgWidth(W), .ImgHeight(H), .PixelWidth(8), .BaseAddr(BASE), .CntWidth(CWA)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .threshold_i(thr), .rom(bus_a),
    .edge_valid_o(ev_a), .edge_o(e_a), .edge_count_o(cnt_a), .busy_o(busy_a), .done_o(done_a));

  user_edge_scan #(.ImgWidth(W), .ImgHeight(H), .PixelWidth(8), .BaseAddr(BASE), .CntWidth(CWB)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .threshold_i(thr), .rom(bus_b),
    .edge_valid_o(ev_b), .edge_o(e_b), .edge_count_o(cnt_b), .busy_o(busy_b), .done_o(done_b));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] img      [N];
  bit         exp_edge [N];
  int         exp_cum  [N+1];
  logic       obs_edge [N];

  // Reference: edge if a reference pixel exists and |p - ref| > thr.
  task automatic build_model(input bit m, input logic [7:0] t);
    exp_cum[0] = 0;
    for (int n = 0; n < N; n++) begin
      int c, r, p, rp, diff;
      bit has;
      c = n % W;
      r = n / W;
      p = int'(img[n]);
      rp = 0;
      has = m ? (r > 0) : (c > 0);
      if (has) rp = m ? int'(img[n - W]) : int'(img[n - 1]);
      diff = (p > rp) ? p - rp : rp - p;
      exp_edge[n] = has && (diff > int'(t));
      exp_cum[n+1] = exp_cum[n] + (exp_edge[n] ? 1 : 0);
    end
  endtask

  function automatic int sat(input int x, input int cw);
    int mx;
    mx = (1 << cw) - 1;
    return (x > mx) ? mx : x;
  endfunction

  task automatic drive_rom(input logic v, input logic [31:0] d);
    bus_a.rom_valid_i = v;
    bus_a.rom_data_i  = d;
    bus_b.rom_valid_i = v;
    bus_b.rom_data_i  = d;
  endtask

  // Plays one full scan of img[]. dly = ROM latency in cycles; toggle_start
  // re-pulses start mid-scan; abort_at >= 0 resets during that pixel's fetch.
  task automatic run_scan(input bit m, input logic [7:0] t, input int dly,
                          input bit toggle_start, input int abort_at, input string tag);
    logic [31:0] rnd;
    logic [31:0] exp_addr;
    int k;
    build_model(m, t);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = m; thr = t;
    @(negedge clk);
    mode = ~m; thr = ~t;
    for (int n = 0; n < N; n++) begin
      k = 0;
      while (bus_a.rom_req_o !== 1'b1 && k < 10) begin
        @(negedge clk);
        k++;
      end
      tests++;
      if (bus_a.rom_req_o !== 1'b1) begin
        fails++;
        $display("FAIL %s req_timeout pix=%0d: rom_req_o=%b required 1", tag, n, bus_a.rom_req_o);
        start = 1'b0;
        return;
      end
      exp_addr = BASE + 32'(4 * n);
      tests++;
      if (bus_a.rom_addr_o !== exp_addr || bus_b.rom_addr_o !== exp_addr) begin
        fails++;
        $display("FAIL %s addr pix=%0d: got %h/%h required %h", tag, n, bus_a.rom_addr_o, bus_b.rom_addr_o, exp_addr);
      end
      tests++;
      if (cnt_a !== CWA'(sat(exp_cum[n], CWA)) || cnt_b !== CWB'(sat(exp_cum[n], CWB))) begin
        fails++;
        $display("FAIL %s count pix=%0d: got %0d/%0d required %0d/%0d", tag, n, cnt_a, cnt_b,
                 sat(exp_cum[n], CWA), sat(exp_cum[n], CWB));
      end
      if (n == abort_at) begin
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (bus_a.rom_req_o !== 1'b0 || busy_a !== 1'b0 || cnt_a !== '0 || cnt_b !== '0 ||
            ev_a !== 1'b0 || e_a !== 1'b0 || done_a !== 1'b0 || busy_b !== 1'b0) begin
          fails++;
          $display("FAIL %s abort: req=%b busy=%b/%b cnt=%0d/%0d ev=%b edge=%b done=%b required all 0",
                   tag, bus_a.rom_req_o, busy_a, busy_b, cnt_a, cnt_b, ev_a, e_a, done_a);
        end
        rst = 1'b0;
        drive_rom(1'b1, {24'h0, img[n]});
        for (int d = 0; d < 3; d++) begin
          @(negedge clk);
          tests++;
          if (bus_a.rom_req_o !== 1'b0 || busy_a !== 1'b0 || ev_a !== 1'b0 || cnt_a !== '0) begin
            fails++;
            $display("FAIL %s late_valid cyc=%0d: req=%b busy=%b ev=%b cnt=%0d required 0/0/0/0",
                     tag, d, bus_a.rom_req_o, busy_a, ev_a, cnt_a);
          end
        end
        drive_rom(1'b0, 32'h0);
        return;
      end
      for (int d = 0; d < dly; d++) begin
        @(negedge clk);
        tests++;
        if (bus_a.rom_req_o !== 1'b1 || bus_a.rom_addr_o !== exp_addr || ev_a !== 1'b0) begin
          fails++;
          $display("FAIL %s stall pix=%0d cyc=%0d: req=%b addr=%h ev=%b required 1/%h/0",
                   tag, n, d, bus_a.rom_req_o, bus_a.rom_addr_o, ev_a, exp_addr);
        end
      end
      rnd = $urandom();
      drive_rom(1'b1, {rnd[31:8], img[n]});
      @(negedge clk);
      rnd = $urandom();
      drive_rom(1'b0, rnd);
      obs_edge[n] = e_a;
      tests++;
      if (ev_a !== 1'b1 || e_a !== exp_edge[n] || ev_b !== 1'b1 || e_b !== exp_edge[n] ||
          bus_a.rom_req_o !== 1'b0) begin
        fails++;
        $display("FAIL %s edge pix=%0d: ev=%b/%b edge=%b/%b req=%b required 1/1 %b/%b 0",
                 tag, n, ev_a, ev_b, e_a, e_b, bus_a.rom_req_o, exp_edge[n], exp_edge[n]);
      end
      if (toggle_start && n == 2) start = 1'b0;
      if (toggle_start && n == 3) start = 1'b1;
    end
    @(negedge clk);
    tests++;
    if (done_a !== 1'b1 || done_b !== 1'b1 || busy_a !== 1'b1 || ev_a !== 1'b0 ||
        cnt_a !== CWA'(sat(exp_cum[N], CWA)) || cnt_b !== CWB'(sat(exp_cum[N], CWB))) begin
      fails++;
      $display("FAIL %s done: done=%b/%b busy=%b ev=%b cnt=%0d/%0d required 1/1 1 0 %0d/%0d", tag,
               done_a, done_b, busy_a, ev_a, cnt_a, cnt_b, sat(exp_cum[N], CWA), sat(exp_cum[N], CWB));
    end
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      tests++;
      if (done_a !== 1'b0 || busy_a !== 1'b0 || bus_a.rom_req_o !== 1'b0 ||
          cnt_a !== CWA'(sat(exp_cum[N], CWA))) begin
        fails++;
        $display("FAIL %s idle_hold cyc=%0d: done=%b busy=%b req=%b cnt=%0d required 0/0/0/%0d",
                 tag, d, done_a, busy_a, bus_a.rom_req_o, cnt_a, sat(exp_cum[N], CWA));
      end
    end
    start = 1'b0;
  endtask

  task automatic load_rows(input logic [7:0] r0 [W], input logic [7:0] r1 [W]);
    for (int c = 0; c < W; c++) begin
      img[c]     = r0[c];
      img[W + c] = r1[c];
    end
  endtask

  task automatic test_reset();
    drive_rom(1'b0, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (bus_a.rom_req_o !== 1'b0 || ev_a !== 1'b0 || e_a !== 1'b0 || done_a !== 1'b0 ||
        busy_a !== 1'b0 || cnt_a !== '0 || cnt_b !== '0) begin
      fails++;
      $display("FAIL reset: req=%b ev=%b edge=%b done=%b busy=%b cnt=%0d/%0d required all 0",
               bus_a.rom_req_o, ev_a, e_a, done_a, busy_a, cnt_a, cnt_b);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_horizontal();
    load_rows('{8'd10, 8'd10, 8'd50, 8'd50}, '{8'd0, 8'd0, 8'd0, 8'd0});
    run_scan(1'b0, 8'd20, 0, 1'b0, -1, "horiz");
    tests++;
    if (cnt_a !== 8'd1 || obs_edge[2] !== 1'b1 || obs_edge[3] !== 1'b0) begin
      fails++;
      $display("FAIL horiz_direct: cnt=%0d e2=%b e3=%b required 1 1 0", cnt_a, obs_edge[2], obs_edge[3]);
    end
  endtask

  task automatic test_vertical();
    load_rows('{8'd10, 8'd10, 8'd50, 8'd50}, '{8'd0, 8'd0, 8'd0, 8'd0});
    run_scan(1'b1, 8'd20, 0, 1'b0, -1, "vert");
    tests++;
    if (cnt_a !== 8'd2 || obs_edge[6] !== 1'b1 || obs_edge[7] !== 1'b1 || obs_edge[2] !== 1'b0) begin
      fails++;
      $display("FAIL vert_direct: cnt=%0d e6=%b e7=%b e2=%b required 2 1 1 0",
               cnt_a, obs_edge[6], obs_edge[7], obs_edge[2]);
    end
  endtask

  task automatic test_threshold_equal();
    load_rows('{8'd10, 8'd30, 8'd30, 8'd9}, '{8'd30, 8'd50, 8'd51, 8'd29});
    run_scan(1'b0, 8'd20, 0, 1'b0, -1, "thr_equal");
    tests++;
    if (obs_edge[1] !== 1'b0 || obs_edge[3] !== 1'b1) begin
      fails++;
      $display("FAIL thr_equal_direct: e1=%b e3=%b required 0 1", obs_edge[1], obs_edge[3]);
    end
  endtask

  task automatic test_slow_rom();
    load_rows('{8'd10, 8'd10, 8'd50, 8'd50}, '{8'd0, 8'd0, 8'd0, 8'd0});
    run_scan(1'b0, 8'd20, 3, 1'b0, -1, "slow_rom");
    tests++;
    if (cnt_a !== 8'd1) begin
      fails++;
      $display("FAIL slow_rom_direct: cnt=%0d required 1", cnt_a);
    end
  endtask

  task automatic test_saturation_busy_start();
    load_rows('{8'd0, 8'd255, 8'd0, 8'd255}, '{8'd255, 8'd0, 8'd255, 8'd0});
    run_scan(1'b0, 8'd100, 1, 1'b1, -1, "saturate");
    tests++;
    if (cnt_b !== 2'd3 || cnt_a !== 8'd6) begin
      fails++;
      $display("FAIL saturate_direct: cnt=%0d/%0d required 6/3", cnt_a, cnt_b);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      for (int n = 0; n < N; n++) img[n] = 8'($urandom_range(0, 255));
      run_scan(1'($urandom_range(0, 1)), 8'($urandom_range(0, 120)), $urandom_range(0, 2), 1'b0, -1, "random");
    end
  endtask

  task automatic test_reset_midscan();
    for (int n = 0; n < N; n++) img[n] = 8'($urandom_range(0, 255));
    run_scan(1'b0, 8'd30, 0, 1'b0, 5, "reset_mid");
    load_rows('{8'd10, 8'd10, 8'd50, 8'd50}, '{8'd0, 8'd0, 8'd0, 8'd0});
    run_scan(1'b1, 8'd20, 0, 1'b0, -1, "after_reset");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required scan completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_rom(1'b0, 32'h0);
    test_reset();
    test_horizontal();
    test_vertical();
    test_threshold_equal();
    test_slow_rom();
    test_saturation_busy_start();
    test_random();
    test_reset_midscan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
